// File: rtl/ex_alu_stage_if.sv
// rtl/ex_alu_stage_if.sv - operand bundle into the execute stage, EX/MEM latch and stall request out
//
// Purpose: groups every non-clock/reset signal of ex_alu_stage.
//   master : upstream side (operand-read latch / hazard unit), drives the operand bundle
//   slave  : the execute stage itself, drives the EX/MEM latch and stall_req
// Signals:
//   ena, imm, rd, pc, funct3, rs1_data, rs2_data, flags, acc_size, csr   (into the stage)
//   result_out, store_data_out, rd_out, funct3_out, flags_out,
//   acc_size_out, csr_out, branch_taken_out, branch_target_out, stall_req (out of the stage)
interface ex_alu_stage_if;
  logic        ena;
  logic [31:0] imm;
  logic [4:0]  rd;
  logic [31:0] pc;
  logic [2:0]  funct3;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [16:0] flags;
  logic [1:0]  acc_size;
  logic [11:0] csr;

  logic [31:0] result_out;
  logic [31:0] store_data_out;
  logic [4:0]  rd_out;
  logic [2:0]  funct3_out;
  logic [16:0] flags_out;
  logic [1:0]  acc_size_out;
  logic [11:0] csr_out;
  logic        branch_taken_out;
  logic [31:0] branch_target_out;
  logic        stall_req;

  modport master (
    output ena, imm, rd, pc, funct3, rs1_data, rs2_data, flags, acc_size, csr,
    input  result_out, store_data_out, rd_out, funct3_out, flags_out,
           acc_size_out, csr_out, branch_taken_out, branch_target_out, stall_req
  );

  modport slave (
    input  ena, imm, rd, pc, funct3, rs1_data, rs2_data, flags, acc_size, csr,
    output result_out, store_data_out, rd_out, funct3_out, flags_out,
           acc_size_out, csr_out, branch_taken_out, branch_target_out, stall_req
  );
endinterface

// File: rtl/ex_alu_stage.sv
// rtl/ex_alu_stage.sv - execute stage: ALU, branch/jump resolution, effective address, EX/MEM latch
//
// Purpose: computes the execute-stage result for one decoded instruction and
// registers it into the EX/MEM output latch. Shifts are done serially, one bit
// per cycle, holding stall_req high until the result is latched.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - ex_alu_stage_if.slave: operand bundle in, EX/MEM latch and stall_req out
// Configuration:
//   EX_FAST_SHIFT_EN - when defined, shifts use a single-cycle barrel shifter,
//                      every op has 1-cycle latency and stall_req is tied to 0
//                      (no SHIFT state, no shift counter).
module ex_alu_stage #(
  parameter int XLEN = 32
) (
  input logic           clk,
  input logic           rst,
  ex_alu_stage_if.slave bus
);

  // EX/MEM latch contents; all-zero is the bubble.
  typedef struct packed {
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] store_data;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic [16:0]     flags;
    logic [1:0]      acc_size;
    logic [11:0]     csr;
    logic            taken;
    logic [XLEN-1:0] target;
  } ex_mem_t;

  // What the EX/MEM latch loads at the next edge.
  typedef enum logic [1:0] {
    LD_ZERO,
    LD_NORMAL,
    LD_SHIFT
  } load_sel_t;

  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [4:0]      shamt;
  logic            is_bubble;
  logic            is_alu;
  logic            is_shift;
  logic [XLEN-1:0] alu_res;
  logic            br_cond;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] res_d;
  logic            taken_d;
  logic [XLEN-1:0] target_d;
  load_sel_t       load_sel;
  ex_mem_t         out_d;
  ex_mem_t         out_q;

  // ---------------------------------------------------------------------------
  // Operand selection and decode
  // ---------------------------------------------------------------------------
  always_comb begin
    op_a      = bus.rs1_data;
    op_b      = bus.flags[0] ? bus.rs2_data : bus.imm;
    shamt     = op_b[4:0];
    is_bubble = (bus.flags == 17'd0);
    // Any of LUI..CSR takes precedence over the ALU flags.
    is_alu    = (bus.flags[1:0] != 2'b00) && (bus.flags[10:3] == 8'd0);
    // funct3 001 (SLL) and 101 (SRL/SRA) are the shifts.
    is_shift  = is_alu && (bus.funct3[1:0] == 2'b01);
  end

  // ---------------------------------------------------------------------------
  // ALU
  // ---------------------------------------------------------------------------
  always_comb begin
    alu_res = '0;
    case (bus.funct3)
      3'b000: alu_res = (bus.flags[0] && bus.flags[2]) ? (op_a - op_b) : (op_a + op_b);
`ifdef EX_FAST_SHIFT_EN
      3'b001: alu_res = op_a << shamt;
      3'b101: alu_res = bus.flags[2] ? XLEN'($signed(op_a) >>> shamt) : (op_a >> shamt);
`else
      // Only a zero shift amount completes here; non-zero amounts go serial.
      3'b001: alu_res = op_a;
      3'b101: alu_res = op_a;
`endif
      3'b010: alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      3'b011: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      3'b100: alu_res = op_a ^ op_b;
      3'b110: alu_res = op_a | op_b;
      3'b111: alu_res = op_a & op_b;
      default: alu_res = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Branch condition: always rs1 against rs2, never the immediate.
  // ---------------------------------------------------------------------------
  always_comb begin
    br_cond = 1'b0;
    case (bus.funct3)
      3'b000:  br_cond = (bus.rs1_data == bus.rs2_data);
      3'b001:  br_cond = (bus.rs1_data != bus.rs2_data);
      3'b100:  br_cond = ($signed(bus.rs1_data) <  $signed(bus.rs2_data));
      3'b101:  br_cond = ($signed(bus.rs1_data) >= $signed(bus.rs2_data));
      3'b110:  br_cond = (bus.rs1_data <  bus.rs2_data);
      3'b111:  br_cond = (bus.rs1_data >= bus.rs2_data);
      default: br_cond = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Result / redirect selection
  // ---------------------------------------------------------------------------
  always_comb begin
    jalr_sum = bus.rs1_data + bus.imm;
    res_d    = '0;
    taken_d  = 1'b0;
    target_d = '0;
    if (bus.flags[3]) begin
      res_d = bus.imm;
    end else if (bus.flags[4]) begin
      res_d = bus.pc + bus.imm;
    end else if (bus.flags[5]) begin
      res_d    = bus.pc + XLEN'(4);
      taken_d  = 1'b1;
      target_d = bus.pc + bus.imm;
    end else if (bus.flags[6]) begin
      res_d    = bus.pc + XLEN'(4);
      taken_d  = 1'b1;
      target_d = {jalr_sum[XLEN-1:1], 1'b0};
    end else if (bus.flags[7]) begin
      taken_d  = br_cond;
      target_d = bus.pc + bus.imm;
    end else if (bus.flags[8] || bus.flags[9]) begin
      res_d = bus.rs1_data + bus.imm;
    end else if (bus.flags[10]) begin
      res_d = bus.rs1_data;
    end else if (is_alu) begin
      res_d = alu_res;
    end
  end

`ifdef EX_FAST_SHIFT_EN
  // ---------------------------------------------------------------------------
  // Single-cycle build: nothing ever stalls.
  // ---------------------------------------------------------------------------
  always_comb begin
    load_sel = (bus.ena && !is_bubble) ? LD_NORMAL : LD_ZERO;
  end

  assign bus.stall_req = 1'b0;

  // Shift status is irrelevant when every op is single-cycle.
  logic unused_shift;
  assign unused_shift = is_shift;
`else
  // ---------------------------------------------------------------------------
  // Serial shifter
  // ---------------------------------------------------------------------------
  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_t;

  // Fields frozen at issue so the upstream bundle can change under a shift.
  typedef struct packed {
    logic [XLEN-1:0] store_data;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic [16:0]     flags;
    logic [1:0]      acc_size;
    logic [11:0]     csr;
    logic            right;   // SRL/SRA
    logic            arith;   // SRA
  } cap_t;

  state_t          state_q;
  state_t          state_d;
  logic [4:0]      cnt_q;
  logic [4:0]      cnt_d;
  logic [XLEN-1:0] sh_val_q;
  logic [XLEN-1:0] sh_val_d;
  logic [XLEN-1:0] sh_step;
  logic            capture;
  logic            stall;
  cap_t            cap_q;

  // One-bit step of the captured shift.
  always_comb begin
    if (!cap_q.right) begin
      sh_step = {sh_val_q[XLEN-2:0], 1'b0};
    end else if (cap_q.arith) begin
      sh_step = {sh_val_q[XLEN-1], sh_val_q[XLEN-1:1]};
    end else begin
      sh_step = {1'b0, sh_val_q[XLEN-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      sh_val_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sh_val_q <= sh_val_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sh_val_d = sh_val_q;
    capture  = 1'b0;
    stall    = 1'b0;
    load_sel = LD_ZERO;
    // A dropped enable wins over issue and completion alike.
    if (!bus.ena) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (is_shift && (shamt != 5'd0)) begin
            capture  = 1'b1;
            sh_val_d = op_a;
            cnt_d    = shamt;
            state_d  = S_SHIFT;
            stall    = 1'b1;
          end else if (!is_bubble) begin
            load_sel = LD_NORMAL;
          end
        end
        S_SHIFT: begin
          stall    = 1'b1;
          sh_val_d = sh_step;
          cnt_d    = cnt_q - 5'd1;
          if (cnt_q == 5'd1) begin
            state_d  = S_IDLE;
            load_sel = LD_SHIFT;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_q <= '0;
    end else if (capture) begin
      cap_q.store_data <= bus.rs2_data;
      cap_q.rd         <= bus.rd;
      cap_q.funct3     <= bus.funct3;
      cap_q.flags      <= bus.flags;
      cap_q.acc_size   <= bus.acc_size;
      cap_q.csr        <= bus.csr;
      cap_q.right      <= bus.funct3[2];
      cap_q.arith      <= bus.funct3[2] & bus.flags[2];
    end
  end

  // The issue-cycle stall is combinational from the inputs, so it is masked
  // while reset is held to keep the hazard unit from seeing a phantom request.
  assign bus.stall_req = stall & ~rst;
`endif

  // ---------------------------------------------------------------------------
  // EX/MEM latch
  // ---------------------------------------------------------------------------
  always_comb begin
    out_d = '0;
    case (load_sel)
      LD_NORMAL: begin
        out_d.result     = res_d;
        out_d.store_data = bus.rs2_data;
        out_d.rd         = bus.rd;
        out_d.funct3     = bus.funct3;
        out_d.flags      = bus.flags;
        out_d.acc_size   = bus.acc_size;
        out_d.csr        = bus.csr;
        out_d.taken      = taken_d;
        out_d.target     = target_d;
      end
`ifndef EX_FAST_SHIFT_EN
      LD_SHIFT: begin
        // The last step is taken on the same edge the latch loads.
        out_d.result     = sh_step;
        out_d.store_data = cap_q.store_data;
        out_d.rd         = cap_q.rd;
        out_d.funct3     = cap_q.funct3;
        out_d.flags      = cap_q.flags;
        out_d.acc_size   = cap_q.acc_size;
        out_d.csr        = cap_q.csr;
      end
`endif
      default: out_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign bus.result_out        = out_q.result;
  assign bus.store_data_out    = out_q.store_data;
  assign bus.rd_out            = out_q.rd;
  assign bus.funct3_out        = out_q.funct3;
  assign bus.flags_out         = out_q.flags;
  assign bus.acc_size_out      = out_q.acc_size;
  assign bus.csr_out           = out_q.csr;
  assign bus.branch_taken_out  = out_q.taken;
  assign bus.branch_target_out = out_q.target;

endmodule

// File: tb/tb_ex_alu_stage.sv
// tb/tb_ex_alu_stage.sv - scoreboard testbench for ex_alu_stage
module tb_ex_alu_stage;

  typedef struct packed {
    logic [31:0] result;
    logic [31:0] store_data;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [16:0] flags;
    logic [1:0]  acc_size;
    logic [11:0] csr;
    logic        taken;
    logic [31:0] target;
  } exp_t;

`ifdef EX_FAST_SHIFT_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   tag;
  exp_t sb[$];

  ex_alu_stage_if bus_if ();

  ex_alu_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: any non-bubble EX/MEM content must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus_if.flags_out != 17'd0) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got flags_out=%h result_out=%h expected none",
                 bus_if.flags_out, bus_if.result_out);
      end else begin
        e = sb.pop_front();
        check("sb_result",   bus_if.result_out,        e.result);
        check("sb_store",    bus_if.store_data_out,    e.store_data);
        check("sb_rd",       32'(bus_if.rd_out),       32'(e.rd));
        check("sb_funct3",   32'(bus_if.funct3_out),   32'(e.funct3));
        check("sb_flags",    32'(bus_if.flags_out),    32'(e.flags));
        check("sb_acc_size", 32'(bus_if.acc_size_out), 32'(e.acc_size));
        check("sb_csr",      32'(bus_if.csr_out),      32'(e.csr));
        check("sb_taken",    32'(bus_if.branch_taken_out), 32'(e.taken));
        check("sb_target",   bus_if.branch_target_out, e.target);
      end
    end
  end

  task automatic bubble();
    bus_if.ena = 1'b1;
    bus_if.flags = '0;
    bus_if.funct3 = '0;
    bus_if.rs1_data = 32'h5;
    bus_if.rs2_data = 32'hDEADBEEF;
    bus_if.imm = 32'h10;
    bus_if.pc = 32'h80;
    bus_if.rd = 5'd3;
    bus_if.acc_size = 2'd1;
    bus_if.csr = 12'h111;
  endtask

  task automatic drive(input logic [16:0] f, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] im, input logic [31:0] p,
                       input logic [4:0] r);
    tag++;
    bus_if.ena = 1'b1;
    bus_if.flags = f;
    bus_if.funct3 = f3;
    bus_if.rs1_data = a;
    bus_if.rs2_data = b;
    bus_if.imm = im;
    bus_if.pc = p;
    bus_if.rd = r;
    bus_if.acc_size = 2'(tag);
    bus_if.csr = 12'h300 + 12'(tag);
  endtask

  // Expected latch contents for the bundle the bench is currently driving.
  function automatic exp_t mk(input logic [31:0] res, input logic tk, input logic [31:0] tg);
    exp_t e;
    e.result = res;
    e.store_data = bus_if.rs2_data;
    e.rd = bus_if.rd;
    e.funct3 = bus_if.funct3;
    e.flags = bus_if.flags;
    e.acc_size = bus_if.acc_size;
    e.csr = bus_if.csr;
    e.taken = tk;
    e.target = tg;
    return e;
  endfunction

  // Single-cycle op; called and returns at posedge+1.
  task automatic send(input logic [16:0] f, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] im, input logic [31:0] p,
                      input logic [4:0] r, input logic [31:0] res, input logic tk,
                      input logic [31:0] tg);
    drive(f, f3, a, b, im, p, r);
    sb.push_back(mk(res, tk, tg));
    @(negedge clk);
    check("stall_single", 32'(bus_if.stall_req), 32'd0);
    @(posedge clk); #1;
    bubble();
    @(negedge clk);
    check("latency_result", bus_if.result_out, res);
    @(posedge clk); #1;
  endtask

  // Shift op with amount n >= 1; serial build stalls in cycles 0..n.
  task automatic send_shift(input logic [16:0] f, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] im, input logic [4:0] r,
                            input logic [31:0] res, input int n);
    int l;
    l = FAST ? 0 : n;
    drive(f, f3, a, b, im, 32'h0, r);
    sb.push_back(mk(res, 1'b0, 32'h0));
    for (int c = 0; c <= l; c++) begin
      @(negedge clk);
      check("stall_shift", 32'(bus_if.stall_req), FAST ? 32'd0 : 32'd1);
      if (c >= 1) check("shift_bubble_out", bus_if.result_out | 32'(bus_if.flags_out), 32'd0);
      @(posedge clk); #1;
      if (c == 0 && l > 0) begin
        // Inputs must be ignored while the shift is in flight.
        bus_if.flags = 17'h1;
        bus_if.funct3 = 3'b000;
        bus_if.rs1_data = 32'h1111;
        bus_if.rs2_data = 32'h2222;
      end
    end
    bubble();
    @(negedge clk);
    check("stall_after_shift", 32'(bus_if.stall_req), 32'd0);
    check("shift_result", bus_if.result_out, res);
    @(posedge clk); #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    tag = 0;
    rst = 1'b1;
    bubble();
    #12;
    check("rst_result", bus_if.result_out, 32'd0);
    check("rst_flags", 32'(bus_if.flags_out), 32'd0);
    check("rst_taken", 32'(bus_if.branch_taken_out), 32'd0);
    check("rst_stall", 32'(bus_if.stall_req), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // ALU register/immediate ops
    send(17'h00001, 3'b000, 32'h5, 32'hFFFFFFFF, 32'h0, 32'h0, 5'd7, 32'h4, 1'b0, 32'h0);
    check("add_rd", 32'(bus_if.rd_out), 32'd0);
    send(17'h00005, 3'b000, 32'h3, 32'h5, 32'h0, 32'h0, 5'd8, 32'hFFFFFFFE, 1'b0, 32'h0);
    send(17'h00006, 3'b000, 32'h3, 32'h77, 32'h5, 32'h0, 5'd9, 32'h8, 1'b0, 32'h0);
    send(17'h00001, 3'b010, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0, 5'd1, 32'h1, 1'b0, 32'h0);
    send(17'h00001, 3'b011, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0, 5'd2, 32'h0, 1'b0, 32'h0);
    send(17'h00002, 3'b100, 32'hF0F0F0F0, 32'h0, 32'hFF00FF00, 32'h0, 5'd3, 32'h0FF00FF0, 1'b0, 32'h0);
    send(17'h00001, 3'b110, 32'h000000F0, 32'h0000000F, 32'h0, 32'h0, 5'd4, 32'hFF, 1'b0, 32'h0);
    send(17'h00001, 3'b111, 32'hFF00FF00, 32'h0FF00FF0, 32'h0, 32'h0, 5'd5, 32'h0F000F00, 1'b0, 32'h0);
    send(17'h02001, 3'b000, 32'h1, 32'h2, 32'h0, 32'h0, 5'd6, 32'h3, 1'b0, 32'h0);

    // Non-ALU results
    send(17'h00008, 3'b000, 32'h9, 32'h0, 32'h12345000, 32'h0, 5'd10, 32'h12345000, 1'b0, 32'h0);
    send(17'h00010, 3'b000, 32'h9, 32'h0, 32'h2000, 32'h1000, 5'd11, 32'h3000, 1'b0, 32'h0);
    send(17'h00020, 3'b000, 32'h9, 32'h0, 32'h100, 32'h40, 5'd1, 32'h44, 1'b1, 32'h140);
    send(17'h00040, 3'b000, 32'h203, 32'h0, 32'h4, 32'h40, 5'd1, 32'h44, 1'b1, 32'h206);
    send(17'h00080, 3'b100, 32'hFFFFFFFF, 32'h1, 32'hFFFFFFF8, 32'h100, 5'd0, 32'h0, 1'b1, 32'hF8);
    send(17'h00080, 3'b110, 32'hFFFFFFFF, 32'h1, 32'hFFFFFFF8, 32'h100, 5'd0, 32'h0, 1'b0, 32'hF8);
    send(17'h00080, 3'b101, 32'hFFFFFFFF, 32'h1, 32'hFFFFFFF8, 32'h100, 5'd0, 32'h0, 1'b0, 32'hF8);
    send(17'h00080, 3'b111, 32'hFFFFFFFF, 32'h1, 32'hFFFFFFF8, 32'h100, 5'd0, 32'h0, 1'b1, 32'hF8);
    send(17'h00080, 3'b000, 32'h5, 32'h5, 32'h10, 32'h200, 5'd0, 32'h0, 1'b1, 32'h210);
    send(17'h00080, 3'b001, 32'h5, 32'h5, 32'h10, 32'h200, 5'd0, 32'h0, 1'b0, 32'h210);
    send(17'h00080, 3'b010, 32'h5, 32'h5, 32'h10, 32'h200, 5'd0, 32'h0, 1'b0, 32'h210);
    send(17'h00100, 3'b010, 32'h1000, 32'h0, 32'hFFFFFFFC, 32'h0, 5'd12, 32'hFFC, 1'b0, 32'h0);
    send(17'h00200, 3'b010, 32'h2000, 32'hDEADBEEF, 32'h8, 32'h0, 5'd0, 32'h2008, 1'b0, 32'h0);
    send(17'h00400, 3'b001, 32'hABCD, 32'h0, 32'h0, 32'h0, 5'd13, 32'hABCD, 1'b0, 32'h0);

    // Bubble input: all-zero latch even though other fields are non-zero
    bubble();
    @(negedge clk);
    check("bubble_stall", 32'(bus_if.stall_req), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("bubble_result", bus_if.result_out, 32'd0);
    check("bubble_store", bus_if.store_data_out, 32'd0);
    check("bubble_taken", 32'(bus_if.branch_taken_out), 32'd0);
    @(posedge clk); #1;

    // Shifts
    send_shift(17'h00006, 3'b101, 32'h80000000, 32'h0, 32'h4, 5'd14, 32'hF8000000, 4);
    send_shift(17'h00001, 3'b101, 32'h80000000, 32'h21, 32'h0, 5'd15, 32'h40000000, 1);
    send_shift(17'h00005, 3'b101, 32'hF0000000, 32'h2, 32'h0, 5'd16, 32'hFC000000, 2);
    send_shift(17'h00001, 3'b001, 32'h1, 32'h3, 32'h0, 5'd17, 32'h8, 3);
    send_shift(17'h00005, 3'b001, 32'h3, 32'h1, 32'h0, 5'd18, 32'h6, 1);
    send_shift(17'h00002, 3'b101, 32'h80000000, 32'h0, 32'h1F, 5'd19, 32'h1, 31);
    send(17'h00002, 3'b001, 32'h1234, 32'h0, 32'h0, 32'h0, 5'd20, 32'h1234, 1'b0, 32'h0);

`ifndef EX_FAST_SHIFT_EN
    // SLL by 8, enable dropped in cycle 3: aborted, no late result
    drive(17'h00001, 3'b001, 32'h1, 32'h8, 32'h0, 32'h0, 5'd21);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("abort_stall_hi", 32'(bus_if.stall_req), 32'd1);
      @(posedge clk); #1;
    end
    bus_if.ena = 1'b0;
    @(negedge clk);
    check("abort_stall_lo", 32'(bus_if.stall_req), 32'd0);
    @(posedge clk); #1;
    bubble();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("abort_no_result", bus_if.result_out | 32'(bus_if.flags_out), 32'd0);
      check("abort_idle_stall", 32'(bus_if.stall_req), 32'd0);
      @(posedge clk); #1;
    end
`endif

    // ena = 0 after a valid op: the next edge zeroes the latch
    drive(17'h00001, 3'b000, 32'h10, 32'h20, 32'h0, 32'h0, 5'd22);
    sb.push_back(mk(32'h30, 1'b0, 32'h0));
    @(posedge clk); #1;
    drive(17'h00001, 3'b000, 32'h1, 32'h1, 32'h0, 32'h0, 5'd23);
    bus_if.ena = 1'b0;
    @(negedge clk);
    check("ena_low_stall", 32'(bus_if.stall_req), 32'd0);
    @(posedge clk); #1;
    bubble();
    @(negedge clk);
    check("ena_low_zero", bus_if.result_out | 32'(bus_if.flags_out), 32'd0);
    @(posedge clk); #1;

    // Asynchronous reset clears a loaded latch immediately
    drive(17'h00001, 3'b000, 32'h1, 32'h2, 32'h0, 32'h0, 5'd24);
    @(posedge clk); #1;
    bubble();
    check("pre_rst_result", bus_if.result_out, 32'h3);
    #1 rst = 1'b1;
    #1;
    check("async_rst_result", bus_if.result_out, 32'd0);
    check("async_rst_rd", 32'(bus_if.rd_out), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

`ifndef EX_FAST_SHIFT_EN
    // Reset in cycle 2 of SLL by 10 discards the shift
    drive(17'h00001, 3'b001, 32'h1, 32'hA, 32'h0, 32'h0, 5'd25);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rst_shift_stall", 32'(bus_if.stall_req), 32'd1);
      if (c < 2) begin
        @(posedge clk); #1;
      end
    end
    #1 rst = 1'b1;
    bubble();
    #1;
    check("mid_rst_stall", 32'(bus_if.stall_req), 32'd0);
    check("mid_rst_result", bus_if.result_out | 32'(bus_if.flags_out), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check("rst_discard", bus_if.result_out | 32'(bus_if.flags_out), 32'd0);
      @(posedge clk); #1;
    end
`endif

    send(17'h00001, 3'b000, 32'h5, 32'hFFFFFFFF, 32'h0, 32'h0, 5'd7, 32'h4, 1'b0, 32'h0);

    repeat (2) @(posedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ex_alu_stage.md
Name: ex_alu_stage

Overview:
- Execute stage directly downstream of the operand-read latch.
- Consumes the decoded, register-read operand bundle and computes ALU results, branch/jump decisions and effective addresses.
- Registers the results into an EX/MEM output latch for the memory stage.
- Shifts run one bit per cycle, so the block raises a stall request to the hazard logic while a shift is in flight.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- ena  in  1  pipeline enable; 0 inserts a bubble and aborts any shift in flight
- imm  in  32  immediate
- rd  in  5  destination register
- pc  in  32  instruction PC
- funct3  in  3  funct3 field
- rs1_data  in  32  operand 1
- rs2_data  in  32  operand 2
- flags  in  17  decode flags; all-zero means bubble
- acc_size  in  2  memory access size, passed through
- csr  in  12  CSR address, passed through
- result_out  out  32  ALU result, link address or effective address
- store_data_out  out  32  rs2_data, passed through
- rd_out  out  5  destination register
- funct3_out  out  3  funct3, passed through
- flags_out  out  17  flags, passed through
- acc_size_out  out  2  acc_size, passed through
- csr_out  out  12  csr, passed through
- branch_taken_out  out  1  redirect request
- branch_target_out  out  32  redirect target
- stall_req  out  1  hazard unit must hold the upstream stages

Behaviour:
- Flag bits:
  - [0] ALU register-register op
  - [1] ALU immediate op
  - [2] alternate op (SUB/SRA)
  - [3] LUI
  - [4] AUIPC
  - [5] JAL
  - [6] JALR
  - [7] branch
  - [8] load
  - [9] store
  - [10] CSR
  - [16:11] passed through, not interpreted here
- Operand B is rs2_data when flags[0] is set, otherwise imm.
- ALU ops by funct3:
  - 000 ADD; SUB only when flags[0] and flags[2] are both set
  - 001 SLL
  - 010 SLT (signed)
  - 011 SLTU
  - 100 XOR
  - 101 SRL; SRA when flags[2] is set
  - 110 OR
  - 111 AND
- All arithmetic is modulo 2^32.
- Shift amount is B[4:0].
- Non-ALU results:
  - LUI: result = imm.
  - AUIPC: result = pc + imm.
  - JAL: result = pc + 4; taken = 1; target = pc + imm.
  - JALR: result = pc + 4; taken = 1; target = (rs1_data + imm) with bit 0 forced to 0.
  - Branch: result = 0; target = pc + imm; taken per funct3: 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU; funct3 010 and 011 give taken = 0.
  - Load/store: result = rs1_data + imm.
  - CSR: result = rs1_data.
- State machine has two states, IDLE and SHIFT.
- IDLE, no shift or shift amount 0:
  - All output registers load at the next edge (1-cycle latency).
  - stall_req = 0.
- IDLE, shift with amount N ≥ 1 (issue cycle 0):
  - Capture operand A, N, the shift kind and all pass-through fields.
  - Go to SHIFT; stall_req = 1 combinationally.
  - Output registers load the bubble (all 0).
- SHIFT:
  - Each cycle shifts by 1 and decrements the count; stall_req = 1.
  - Inputs are ignored.
  - Output registers hold the bubble.
  - At the edge where the count reaches 0 (end of cycle N), load the result and captured fields, then return to IDLE.
  - stall_req is therefore high in cycles 0..N.
- ena = 0, in any state:
  - Next edge zeroes all outputs and forces IDLE.
  - stall_req = 0 combinationally in that cycle.
  - ena has priority over a shift issue or completion in the same cycle.
- Bubble input (flags == 0): outputs are all zero next edge, including branch_taken_out.
- rst (asynchronous): all outputs = 0, state = IDLE, count = 0, captured operands cleared. An in-flight shift is discarded.

Optional Feature:
- Macro: EX_FAST_SHIFT_EN.
- Defined:
  - Shifts use a single-cycle barrel shifter.
  - All ops have 1-cycle latency.
  - stall_req is constant 0; the SHIFT state and counter are not built.
- Undefined: the serial shift behaviour above.

Test Plan:
- ADD: flags[0], funct3 000, rs1 = 5, rs2 = 0xFFFFFFFF, rd = 7 -> result_out = 4 and rd_out = 7 after one edge; stall_req = 0 throughout.
- SRAI: flags[1]|flags[2], funct3 101, rs1 = 0x80000000, imm = 4 -> stall_req high for 5 cycles; outputs zero during the shift; result_out = 0xF8000000 at the edge ending cycle 4. With the macro: result after 1 edge, stall_req = 0.
- BLT: flags[7], funct3 100, rs1 = 0xFFFFFFFF, rs2 = 1, pc = 0x100, imm = 0xFFFFFFF8 -> branch_taken_out = 1, branch_target_out = 0xF8, result_out = 0.
- JALR: flags[6], rs1 = 0x203, imm = 4, pc = 0x40 -> result_out = 0x44, branch_target_out = 0x206, branch_taken_out = 1.
- SLLI amount 0: rs1 = 0x1234 -> result_out = 0x1234 after 1 edge, no stall. Then SLL amount 8, ena dropped in cycle 3 -> outputs zero next edge, IDLE, stall_req = 0.
- rst pulsed asynchronously mid-SHIFT (cycle 2 of SLL by 10) -> all outputs 0 immediately, stall_req = 0. A following ADD completes normally in 1 cycle.
